// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX line arbiter.
//   arb_state_e : arbiter FSM state (IDLE, LOCKED)
//   UART_LF     : byte value that terminates a console line
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_e;

  localparam logic [7:0] UART_LF = 8'h0A;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req    : request vector, one bit per requester
//   rr_ptr : index searched first; the search wraps past NUM_REQ-1 to 0
//   gnt    : one-hot grant, all zero when no request is set
//   idx    : encoded index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic found;

  // Walk offsets 0..NUM_REQ-1 from rr_ptr; the first requesting slot wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((32'(rr_ptr) + off) % NUM_REQ) == i)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Shares one byte-wide UART transmitter between NUM_REQ requesters so that
// console lines never interleave. The winner of round-robin arbitration owns
// the transmitter until it sends a line feed, reaches MAX_LINE bytes, or stays
// idle for IDLE_TIMEOUT cycles.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid_i  : per-requester byte valid
//   req_data_i   : per-requester byte, requester i at [8*i +: 8]
//   req_ready_o  : per-requester accept (only the owner's bit can be set)
//   tx_valid_o   : byte valid toward the serializer
//   tx_data_o    : byte toward the serializer
//   tx_ready_i   : serializer accepts a byte
//   grant_o      : one-hot current owner, zero while idle
//   busy_o       : high while a line is locked
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_LINE     = 255,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned LINE_W = $clog2(MAX_LINE + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(MAX_LINE);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [LINE_W-1:0]  line_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [NUM_REQ-1:0] grant_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               owner_valid;
  logic [7:0]         owner_data;
  logic [LINE_W-1:0]  line_cnt_inc;
  logic [IDLE_W-1:0]  idle_cnt_inc;
  logic               locked;
  logic               xfer;
  logic               line_done;
  logic               timed_out;
  logic               release_line;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid_i),
    .rr_ptr(rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  // Select the owner's byte stream.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_valid = req_valid_i[i];
        owner_data  = req_data_i[i*8 +: 8];
      end
    end
  end

  // Release decode. LF on the MAX_LINE-th byte is one condition, not two,
  // because both feed a single OR into one state transition.
  always_comb begin
    locked       = (state_q == LOCKED);
    line_cnt_inc = (line_cnt_q == LINE_MAX) ? line_cnt_q : line_cnt_q + 1'b1;
    idle_cnt_inc = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
    xfer         = locked && owner_valid && tx_ready_i;
    line_done    = xfer && ((owner_data == UART_LF) || (line_cnt_inc == LINE_MAX));
    // A pending owner byte keeps the idle counter at zero, so it can never time out.
    timed_out    = locked && !owner_valid && (idle_cnt_inc == IDLE_MAX);
    release_line = line_done || timed_out;
  end

  // Zero-latency passthrough while locked; everything reads zero otherwise,
  // so an asynchronous reset drops tx_valid_o immediately.
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (locked) begin
      tx_valid_o  = owner_valid;
      tx_data_o   = owner_data;
      req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      line_cnt_q <= '0;
      idle_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            state_q    <= LOCKED;
            owner_q    <= arb_idx;
            grant_q    <= arb_gnt;
            line_cnt_q <= '0;
            idle_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (release_line) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            line_cnt_q <= '0;
            idle_cnt_q <= '0;
          end else begin
            if (xfer) begin
              line_cnt_q <= line_cnt_inc;
            end
            idle_cnt_q <= owner_valid ? '0 : idle_cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Self-checking bench for uart_tx_line_arbiter (NUM_REQ=4, MAX_LINE=4,
// IDLE_TIMEOUT=16). Each requester is fed from a byte FIFO; the expected
// {source, byte} transfer order is queued by each scenario and popped by a
// monitor on every accepted transfer.
module tb_uart_tx_line_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned MAXL  = 4;
  localparam int unsigned TMO   = 16;
  localparam int          DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0]     exp_q[$];
  logic [7:0]      src_mem [NREQ][DEPTH];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] acc;
  logic [2:0]      mon_who;
  logic [10:0]     mon_want;

  uart_tx_line_arbiter #(
    .NUM_REQ     (NREQ),
    .MAX_LINE    (MAXL),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Requester models: pop on an accepted byte, present the next one 1 time unit later.
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) head[i]++;
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = (head[i] != tail[i]);
      req_data[i*8 +: 8] = src_mem[i][head[i] % DEPTH];
    end
  end

  always @(negedge clk) acc = req_valid & req_ready & {NREQ{rst_n}};

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      mon_who = 3'd7;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) mon_who = 3'(i);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra: got src %0d byte %02h, required no transfer",
                 mon_who, tx_data);
      end else begin
        mon_want = exp_q.pop_front();
        if ({mon_who, tx_data} !== mon_want) begin
          n_err++;
          $display("FAIL scoreboard_byte: got src %0d byte %02h, required src %0d byte %02h",
                   mon_who, tx_data, mon_want[10:8], mon_want[7:0]);
        end
      end
    end
  end

  task automatic send(input int src, input logic [7:0] b);
    src_mem[src][tail[src] % DEPTH] = b;
    tail[src]++;
  endtask

  task automatic expect_byte(input int src, input logic [7:0] b);
    exp_q.push_back({3'(src), b});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (k < budget && (busy || exp_q.size() != 0 || !srcs_empty())) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_drain: got %0d bytes outstanding busy=%0b, required 0 and idle in %0d cycles",
               name, exp_q.size(), busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({tx_valid, busy, grant, req_ready} !== 10'd0) begin
      n_err++;
      $display("FAIL empty_idle: got valid=%b busy=%b grant=%b ready=%b, required all 0",
               tx_valid, busy, grant, req_ready);
    end
  endtask

  task automatic test_hi_line();
    tx_ready = 1'b1;
    send(0, 8'h68); send(0, 8'h69); send(0, 8'h0A); send(2, 8'h33);
    expect_byte(0, 8'h68); expect_byte(0, 8'h69); expect_byte(0, 8'h0A); expect_byte(2, 8'h33);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL hi_latency: got %b, required 0000", grant); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL hi_grant: got %b, required 0001", grant); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL hi_ready: got %b, required 0001", req_ready); end
    n_cmp++; if (tx_data !== 8'h68) begin n_err++; $display("FAIL hi_first: got %h, required 68", tx_data); end
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_data !== 8'h0A) begin n_err++; $display("FAIL hi_lf: got %h, required 0a", tx_data); end
    @(negedge clk);
    n_cmp++;
    if ({tx_valid, busy, grant, req_ready} !== 10'd0) begin
      n_err++;
      $display("FAIL hi_bubble: got valid=%b busy=%b grant=%b ready=%b, required all 0",
               tx_valid, busy, grant, req_ready);
    end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL hi_next_grant: got %b, required 0100", grant); end
    drain("hi", 100);
  endtask

  task automatic test_max_line();
    for (int k = 0; k < 12; k++) begin
      send(0, 8'(8'h10 + k));
      send(1, 8'(8'h80 + k));
    end
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) expect_byte(0, 8'(8'h10 + 4 * c + k));
      for (int k = 0; k < 4; k++) expect_byte(1, 8'(8'h80 + 4 * c + k));
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL maxl_grant0: got %b, required 0001", grant); end
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL maxl_release: got busy=%b, required 0", busy); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL maxl_grant1: got %b, required 0010", grant); end
    drain("maxl", 200);
  endtask

  task automatic test_timeout();
    int bad = 0;
    send(0, 8'h41);
    expect_byte(0, 8'h41); expect_byte(2, 8'h42);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL tmo_byte: got %h, required 41", tx_data); end
    send(2, 8'h42);
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || grant !== 4'b0001) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL tmo_early: got %0d cycles released, required 0", bad); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL tmo_ready: got %b, required 0001", req_ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_release: got busy=%b, required 0", busy); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL tmo_next_grant: got %b, required 0100", grant); end
    drain("tmo", 100);
  endtask

  task automatic test_blocked();
    int bad = 0;
    tx_ready = 1'b0;
    send(3, 8'h55); send(1, 8'h66);
    expect_byte(3, 8'h55); expect_byte(1, 8'h66);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL blk_grant: got %b, required 1000", grant); end
    repeat (2000) begin
      @(negedge clk);
      if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0000 ||
          grant !== 4'b1000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL blk_hold: got %0d bad cycles, required 0", bad); end
    @(posedge clk);
    #2 tx_ready = 1'b1;
    drain("blk", 100);
  endtask

  task automatic test_lf_at_max();
    send(2, 8'h01); send(2, 8'h02); send(2, 8'h03); send(2, 8'h0A);
    send(3, 8'h77); send(0, 8'h78);
    expect_byte(2, 8'h01); expect_byte(2, 8'h02); expect_byte(2, 8'h03); expect_byte(2, 8'h0A);
    expect_byte(3, 8'h77); expect_byte(0, 8'h78);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL lfmax_grant: got %b, required 0100", grant); end
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_data !== 8'h0A) begin n_err++; $display("FAIL lfmax_lf: got %h, required 0a", tx_data); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lfmax_release: got busy=%b, required 0", busy); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL lfmax_rr: got %b, required 1000", grant); end
    drain("lfmax", 150);
  endtask

  task automatic test_reset_midline();
    for (int k = 0; k < 10; k++) send(1, 8'(8'h20 + k));
    expect_byte(1, 8'h20); expect_byte(1, 8'h21);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL rstm_grant: got %b, required 0010", grant); end
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, tx_data, busy, grant, req_ready} !== 18'd0) begin
      n_err++;
      $display("FAIL rstm_async: got valid=%b data=%h busy=%b grant=%b ready=%b, required all 0",
               tx_valid, tx_data, busy, grant, req_ready);
    end
    for (int i = 0; i < NREQ; i++) head[i] = tail[i];
    repeat (2) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rstm_sent: got %0d bytes unsent, required 0", exp_q.size()); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(3, 8'h31); send(0, 8'h30);
    expect_byte(0, 8'h30); expect_byte(3, 8'h31);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rstm_rr_ptr: got %b, required 0001", grant); end
    drain("rstm", 100);
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    acc       = '0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int j = 0; j < DEPTH; j++) src_mem[i][j] = 8'h00;
    end
    test_reset();
    test_hi_line();
    test_max_line();
    test_timeout();
    test_blocked();
    test_lf_at_max();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_line_arbiter.md
# uart_tx_line_arbiter

Shares one byte-wide UART transmitter between several software or debug requesters so console output never interleaves mid-line. A requester that wins arbitration owns the transmitter until it completes a line with a line feed (0x0A), hits the maximum line length, or goes idle past a timeout. Ownership then passes round-robin. The block sits between the per-source byte streams and the UART TX serializer's byte input.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_LINE`, default 255: bytes accepted before a forced release, 1..255.
- `IDLE_TIMEOUT`, default 1024: owner idle cycles before a forced release, ≥1.
- `clk`  in  1: sole clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ: per-requester byte valid.
- `req_data_i`  in  NUM_REQ×8: per-requester byte.
- `req_ready_o`  out  NUM_REQ: per-requester accept.
- `tx_valid_o`  out  1: byte valid toward serializer.
- `tx_data_o`  out  8: byte toward serializer.
- `tx_ready_i`  in  1: serializer accepts a byte.
- `grant_o`  out  NUM_REQ: one-hot current owner; all zero when idle.
- `busy_o`  out  1: high while in LOCKED.

## Operation
- States: IDLE, LOCKED.
- IDLE
  - If any `req_valid_i` bit is set, pick the first set bit at or after `rr_ptr`, wrapping.
  - Register it as owner and go to LOCKED on the next edge.
  - Clear the line counter and the idle counter.
- LOCKED
  - Combinational passthrough: `tx_valid_o = req_valid_i[owner]`, `tx_data_o = req_data_i[owner]`, `req_ready_o[owner] = tx_ready_i`.
  - All non-owner `req_ready_o` bits are 0.
- Handshake: a byte transfers when `tx_valid_o && tx_ready_i`. Requesters must hold valid and data stable until ready.
- Line counter: increments on each transfer, saturating at `MAX_LINE`.
- Idle counter:
  - Increments each cycle the owner's valid is low.
  - Clears on any cycle the owner's valid is high.
- Release conditions (LOCKED → IDLE on the next edge):
  - Transfer of 0x0A.
  - Transfer that brings the line count to `MAX_LINE`.
  - Idle counter reaching `IDLE_TIMEOUT` while the owner's valid is low.
- A pending, unaccepted owner byte (valid high) always blocks a timeout release.
- On release, set `rr_ptr` to (owner+1) mod `NUM_REQ`.
- Width rules:
  - Line counter is $clog2(MAX_LINE+1) bits.
  - Idle counter is $clog2(IDLE_TIMEOUT+1) bits and saturates.
  - `rr_ptr` is $clog2(NUM_REQ) bits.
- Simultaneous events:
  - 0x0A transferred on the `MAX_LINE`-th byte causes one release, not two.
  - Non-owner requests arriving in LOCKED are only seen at the next IDLE.

## Timing
- Reset values:
  - Outputs: `tx_valid_o`=0, `tx_data_o`=0x00, `req_ready_o`=0, `grant_o`=0, `busy_o`=0.
  - Internal: `rr_ptr`=0, state IDLE, both counters 0.
- Arbitration latency: request seen in IDLE at cycle N; grant and passthrough active from cycle N+1.
- Data path inside LOCKED: zero latency, combinational. `tx_ready_i` may be high continuously, giving one byte per cycle.
- Release: the releasing transfer at cycle N gives IDLE at N+1 with all outputs 0. The earliest next grant is N+2, so there is one bubble cycle.
- Timeout: with the owner's valid low from cycle N, the release edge is at N+`IDLE_TIMEOUT`.
- Reset asserted mid-line: immediate return to reset values. The partially sent line is abandoned; the serializer sees `tx_valid_o` drop asynchronously.
- Empty case: IDLE with no requests holds outputs at 0 indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - State enum `arb_state_e` {IDLE, LOCKED}.
  - Constant `UART_LF = 8'h0A`.
- Sub-module `rr_arbiter`:
  - Parameterized `NUM_REQ`, purely combinational.
  - Inputs: request vector and `rr_ptr`. Outputs: one-hot grant and encoded index.
- Top level holds the FSM, counters, owner register and output muxes. No other hierarchy.

## Test plan
- Reset, then `req_valid_i`=0b0101 → grant_o=0b0001 one cycle later. Requester 0 sends "hi\n" (0x68,0x69,0x0A) with `tx_ready_i`=1 → three transfers, then IDLE, then grant_o=0b0100 two cycles after the 0x0A.
- Requesters 0 and 1 stream continuously without LF, MAX_LINE=4 → exactly 4 bytes from 0, release, 4 bytes from 1, then back to 0, bytes never interleaved.
- Owner sends 0x41 then drops valid, IDLE_TIMEOUT=16 → release exactly 16 cycles after valid falls. A pending requester 2 is granted 1 cycle later.
- Owner valid high with `tx_ready_i`=0 for 2000 cycles → no timeout release, `tx_data_o` stable, non-owner ready bits 0.
- 0x0A sent as the `MAX_LINE`-th byte → single release, `rr_ptr` advances by one.
- `rst_n` pulled low mid-line (byte 3 of 10) → all outputs 0 at once, `rr_ptr`=0. After reset, requester 0 wins over requester 3.
